// File: rtl/seq_div_rem_unit.sv
// Multi-cycle radix-2 restoring divide/remainder unit with RISC-V divide-by-zero
// and signed-overflow semantics, valid/ready handshaked on input and output.
module seq_div_rem_unit #(
   parameter int WIDTH     = 32,
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             op_signed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t         state;
   logic [CW-1:0]  count;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] dvs;
   logic           neg_q;
   logic           neg_r;

   logic             signed_mode;
   logic [WIDTH-1:0] dividend_abs;
   logic [WIDTH-1:0] divisor_abs;
   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] diff;
   logic             take;
   logic [WIDTH-1:0] rem_step;
   logic [WIDTH-1:0] quo_step;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   assign signed_mode  = SIGNED_EN & op_signed;
   assign dividend_abs = (signed_mode && dividend[WIDTH-1]) ? -dividend : dividend;
   assign divisor_abs  = (signed_mode && divisor[WIDTH-1])  ? -divisor  : divisor;

   // The shifted partial remainder needs WIDTH+1 bits; the difference always fits
   // in WIDTH bits when taken because the remainder stays below the divisor.
   assign shifted  = {rem, quo[WIDTH-1]};
   assign take     = (shifted >= {1'b0, dvs});
   assign diff     = shifted[WIDTH-1:0] - dvs;
   assign rem_step = take ? diff : shifted[WIDTH-1:0];
   assign quo_step = {quo[WIDTH-2:0], take};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         count       <= '0;
         quo         <= '0;
         rem         <= '0;
         dvs         <= '0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (divisor == '0) begin
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                     state       <= DONE;
                  end else begin
                     quo   <= dividend_abs;
                     dvs   <= divisor_abs;
                     rem   <= '0;
                     neg_q <= signed_mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                     neg_r <= signed_mode & dividend[WIDTH-1];
                     count <= '0;
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               quo   <= quo_step;
               rem   <= rem_step;
               count <= count + 1'b1;
               if (count == LAST) begin
                  quotient    <= neg_q ? -quo_step : quo_step;
                  remainder   <= neg_r ? -rem_step : rem_step;
                  div_by_zero <= 1'b0;
                  state       <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_div_rem_unit.sv
// Directed bench for seq_div_rem_unit: vector table on a 32-bit instance plus
// backpressure, asynchronous reset mid-operation and an 8-bit instance.
module tb_seq_div_rem_unit;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        op_signed;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_by_zero;

   logic        in_valid8;
   logic        in_ready8;
   logic [7:0]  dividend8;
   logic [7:0]  divisor8;
   logic        op_signed8;
   logic        out_valid8;
   logic        out_ready8;
   logic [7:0]  quotient8;
   logic [7:0]  remainder8;
   logic        div_by_zero8;

   int checks   = 0;
   int failures = 0;

   seq_div_rem_unit #(.WIDTH(32), .SIGNED_EN(1'b1)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .divisor(divisor), .op_signed(op_signed),
      .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient),
      .remainder(remainder), .div_by_zero(div_by_zero)
   );

   seq_div_rem_unit #(.WIDTH(8), .SIGNED_EN(1'b1)) dut8 (
      .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
      .dividend(dividend8), .divisor(divisor8), .op_signed(op_signed8),
      .out_valid(out_valid8), .out_ready(out_ready8), .quotient(quotient8),
      .remainder(remainder8), .div_by_zero(div_by_zero8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
   } vec_t;

   vec_t vecs[15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   // Launch one op on the 32-bit unit and wait (bounded) for out_valid.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] q, output logic [31:0] r, output logic dz,
                         output int lat, output logic busy);
      @(negedge clk);
      in_valid  = 1'b1;
      dividend  = a;
      divisor   = b;
      op_signed = s;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      dividend  = $urandom;
      divisor   = $urandom;
      op_signed = ~s;
      busy = in_ready;
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      q  = quotient;
      r  = remainder;
      dz = div_by_zero;
   endtask

   task automatic release_result(input string name);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({name, "_in_ready_after"}, {31'b0, in_ready}, 32'd1);
      check({name, "_out_valid_after"}, {31'b0, out_valid}, 32'd0);
   endtask

   initial begin
      logic [31:0] q, r;
      logic        dz, busy;
      int          lat, seen;

      vecs[0]  = '{32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         1'b0};
      vecs[1]  = '{32'hFFFFFFF9,  32'd2,         1'b1, 32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0};
      vecs[2]  = '{32'd7,         32'hFFFFFFFE,  1'b1, 32'hFFFFFFFD,  32'd1,         1'b0};
      vecs[3]  = '{32'd5,         32'd0,         1'b1, 32'hFFFFFFFF,  32'd5,         1'b1};
      vecs[4]  = '{32'd5,         32'd0,         1'b0, 32'hFFFFFFFF,  32'd5,         1'b1};
      vecs[5]  = '{32'h80000000,  32'hFFFFFFFF,  1'b1, 32'h80000000,  32'd0,         1'b0};
      vecs[6]  = '{32'h80000000,  32'hFFFFFFFF,  1'b0, 32'd0,         32'h80000000,  1'b0};
      vecs[7]  = '{32'hFFFFFFF9,  32'd2,         1'b0, 32'h7FFFFFFC,  32'd1,         1'b0};
      vecs[8]  = '{32'hFFFFFF9C,  32'hFFFFFFF9,  1'b1, 32'd14,        32'hFFFFFFFE,  1'b0};
      vecs[9]  = '{32'h80000000,  32'd1,         1'b1, 32'h80000000,  32'd0,         1'b0};
      vecs[10] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0, 32'd1,         32'd0,         1'b0};
      vecs[11] = '{32'd12345,     32'd1,         1'b0, 32'd12345,     32'd0,         1'b0};
      vecs[12] = '{32'd3,         32'd10,        1'b0, 32'd0,         32'd3,         1'b0};
      vecs[13] = '{32'hFFFFFFF8,  32'd0,         1'b1, 32'hFFFFFFFF,  32'hFFFFFFF8,  1'b1};
      vecs[14] = '{32'h80000000,  32'd2,         1'b1, 32'hC0000000,  32'd0,         1'b0};

      reset = 1'b1;
      in_valid = 1'b0; dividend = '0; divisor = '0; op_signed = 1'b0; out_ready = 1'b0;
      in_valid8 = 1'b0; dividend8 = '0; divisor8 = '0; op_signed8 = 1'b0; out_ready8 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready",    {31'b0, in_ready},    32'd1);
      check("rst_out_valid",   {31'b0, out_valid},   32'd0);
      check("rst_quotient",    quotient,             32'd0);
      check("rst_remainder",   remainder,            32'd0);
      check("rst_div_by_zero", {31'b0, div_by_zero}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 15; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].s, q, r, dz, lat, busy);
         $display("vec %0d: a=0x%08h b=0x%08h s=%0d -> q=0x%08h r=0x%08h dz=%0d lat=%0d",
                  i, vecs[i].a, vecs[i].b, vecs[i].s, q, r, dz, lat);
         check($sformatf("vec%0d_q", i), q, vecs[i].q);
         check($sformatf("vec%0d_r", i), r, vecs[i].r);
         check($sformatf("vec%0d_dz", i), {31'b0, dz}, {31'b0, vecs[i].dz});
         check($sformatf("vec%0d_lat", i), lat, vecs[i].dz ? 32'd0 : 32'd32);
         if (!vecs[i].dz)
            check($sformatf("vec%0d_busy", i), {31'b0, busy}, 32'd0);
         release_result($sformatf("vec%0d", i));
      end

      // Backpressure: result held for 5 cycles while new requests are offered.
      run_op(32'd100, 32'd7, 1'b0, q, r, dz, lat, busy);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         in_valid = 1'b1; dividend = 32'd999; divisor = 32'd1; op_signed = 1'b0;
         @(posedge clk);
         #1;
         check($sformatf("bp%0d_q", c), quotient, 32'd14);
         check($sformatf("bp%0d_r", c), remainder, 32'd2);
         check($sformatf("bp%0d_valid", c), {31'b0, out_valid}, 32'd1);
         check($sformatf("bp%0d_in_ready", c), {31'b0, in_ready}, 32'd0);
         $display("backpressure cycle %0d: q=0x%08h r=0x%08h out_valid=%0d in_ready=%0d",
                  c, quotient, remainder, out_valid, in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      release_result("bp");
      run_op(32'd3, 32'd10, 1'b0, q, r, dz, lat, busy);
      $display("after backpressure: q=0x%08h r=0x%08h lat=%0d", q, r, lat);
      check("bp_next_q", q, 32'd0);
      check("bp_next_r", r, 32'd3);
      check("bp_next_lat", lat, 32'd32);
      release_result("bp_next");

      // Asynchronous reset in the middle of the iteration phase.
      @(negedge clk);
      in_valid = 1'b1; dividend = 32'hFFFFFFFF; divisor = 32'd3; op_signed = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("arst_out_valid", {31'b0, out_valid}, 32'd0);
      check("arst_in_ready",  {31'b0, in_ready},  32'd1);
      check("arst_quotient",  quotient,           32'd0);
      $display("async reset mid-calc: out_valid=%0d in_ready=%0d", out_valid, in_ready);
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         if (out_valid) seen++;
      end
      check("arst_no_result", seen, 32'd0);
      run_op(32'd200, 32'd3, 1'b0, q, r, dz, lat, busy);
      $display("after reset 200/3: q=0x%08h r=0x%08h lat=%0d", q, r, lat);
      check("arst_200_3_q", q, 32'd66);
      check("arst_200_3_r", r, 32'd2);
      check("arst_200_3_lat", lat, 32'd32);
      release_result("arst_200_3");

      // 8-bit instance.
      @(negedge clk);
      in_valid8 = 1'b1; dividend8 = 8'd200; divisor8 = 8'd3; op_signed8 = 1'b0;
      @(posedge clk);
      #1;
      in_valid8 = 1'b0;
      lat = 0;
      while (!out_valid8 && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      $display("w8 200/3: q=%0d r=%0d lat=%0d", quotient8, remainder8, lat);
      check("w8_q", {24'b0, quotient8}, 32'd66);
      check("w8_r", {24'b0, remainder8}, 32'd2);
      check("w8_dz", {31'b0, div_by_zero8}, 32'd0);
      check("w8_lat", lat, 32'd8);
      @(negedge clk);
      out_ready8 = 1'b1;
      @(posedge clk);
      #1;
      out_ready8 = 1'b0;
      check("w8_in_ready_after", {31'b0, in_ready8}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
